reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates the system and CPU resets from the board button, PLL lock and the software reset switch driven by the system register block, and stretches the software-controlled SIL9024 reset into a pulse of guaranteed width. It sits directly downstream of the system register block: that block's reset-switch and SIL9024-reset outputs feed this block. This block's `o_reset` feeds back into the register block's reset, which clears the switch bit and closes the loop.

## Interface
- `FREQUENCY`, 100_000_000: clock frequency in Hz.
- `HOLD_US`, 10: minimum `o_reset` assertion time, in µs.
- `STAGE_CYCLES`, 16: cycles between `o_reset` release and `o_cpu_reset` release.
- `DEBOUNCE_US`, 1000: time `i_button` must be stable before it is accepted, in µs.
- `SIL_US`, 100: minimum `o_sil9024_reset` pulse width, in µs.

Ports:
- `i_clock` in 1: single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_button` in 1: asynchronous, active-high board button.
- `i_pll_locked` in 1: asynchronous PLL lock.
- `i_reset_switch` in 1: synchronous software reset request from the system registers.
- `i_sil9024_reset` in 1: synchronous software SIL9024 reset level from the system registers.
- `o_reset` out 1: system reset, active-high.
- `o_cpu_reset` out 1: CPU reset, active-high, released last.
- `o_sil9024_reset` out 1: stretched SIL9024 reset.
- `o_cause` out 2: last reset cause. 0 = power/`i_reset`, 1 = PLL, 2 = button, 3 = software.
- `o_busy` out 1: high in any state other than RUN.

## Operation
- Cycle counts: `HOLD_CYC = FREQUENCY/1_000_000*HOLD_US`. `DEBOUNCE_CYC` and `SIL_CYC` are derived the same way. Each count is clamped to a minimum of 1.
- Counter widths are `$clog2(max+1)`. Counters saturate and never wrap.
- `i_button` and `i_pll_locked` each pass through a 2-flop synchronizer.
- Button debounce: a counter restarts on every change of the synchronized level. The accepted level updates when the count reaches `DEBOUNCE_CYC`. A trigger is the rising edge of the accepted level.
- Trigger sources: synchronized `i_pll_locked` low (level), button trigger, `i_reset_switch` high (level).
- State machine, four states:
  - POR: entered on `i_reset`. Waits for PLL lock, then goes to HOLD.
  - HOLD: counter runs 0..`HOLD_CYC-1`, then goes to STAGE.
  - STAGE: counter runs 0..`STAGE_CYCLES-1`, then goes to RUN.
  - RUN: any trigger goes to HOLD with the counter cleared.
- Any trigger seen in HOLD or STAGE returns the FSM to HOLD and clears the counter (restart). PLL loss in any state goes to POR.
- Output mapping:
  - `o_reset` = 1 in POR and HOLD.
  - `o_cpu_reset` = 1 in POR, HOLD and STAGE.
  - `o_busy` = 1 whenever the state is not RUN.
- `o_cause` is written on each trigger entry. When triggers coincide, priority is PLL > button > software.
- `i_reset` sets `o_cause` = 0.
- `o_cause` is not cleared by the block's own resets, so software can read it after restart.
- SIL9024 stretcher:
  - A rising edge of `i_sil9024_reset` loads the counter with `SIL_CYC`.
  - `o_sil9024_reset` = (`i_sil9024_reset` | counter≠0 | `o_reset`).
  - A new rising edge during a pulse reloads the counter.

## Timing
- Reset values on `i_reset`:
  - State = POR.
  - `o_reset` = 1, `o_cpu_reset` = 1, `o_busy` = 1.
  - `o_sil9024_reset` = 1.
  - `o_cause` = 0.
  - All counters = 0.
  - Synchronizer and debounce registers = 0.
- All outputs are registered, one cycle after the state update.
- Software switch latency: `i_reset_switch` high in cycle N gives `o_reset` = 1 in cycle N+1.
  - Once `o_reset` clears the switch, the FSM remains in HOLD for exactly `HOLD_CYC` cycles.
  - `o_reset` is low in cycle N+1+`HOLD_CYC`.
  - `o_cpu_reset` falls `STAGE_CYCLES` cycles later.
- PLL latency: 2 synchronizer cycles plus 1 cycle.
- Button latency: 2 synchronizer cycles plus `DEBOUNCE_CYC` cycles plus 1 cycle.
- A trigger held high holds the FSM in HOLD. Release is counted from the cycle after the trigger drops.
- A button press that bounces shorter than `DEBOUNCE_CYC` produces no trigger.

## Structure
- Package `reset_sequencer_pkg`:
  - State enum `state_t` {POR, HOLD, STAGE, RUN}.
  - Cause enum `cause_t`.
  - Helper function `us_to_cycles(freq, us)` implementing the clamped conversion.
- Sub-module `reset_debounce`: synchronizer, debounce counter and rising-edge output. Parameter `CYCLES`. Instantiated for `i_button`.
- Everything else lives in the top module.

## Test plan
All scenarios use `FREQUENCY`=1_000_000, `HOLD_US`=10, `STAGE_CYCLES`=4, `DEBOUNCE_US`=5 and `SIL_US`=20.
- `i_reset` released with `i_pll_locked`=1 → after 2 synchronizer cycles:
  - `o_reset` falls after 10 more cycles.
  - `o_cpu_reset` falls 4 cycles after that.
  - `o_cause`=0 and `o_busy`=0.
- In RUN, pulse `i_reset_switch` for 1 cycle → `o_reset` rises the next cycle and stays high 10 cycles; `o_cause`=3.
- Button glitches of 3 cycles → no reset. A stable press of 6 cycles → reset, `o_cause`=2.
- Drop `i_pll_locked` in STAGE while the switch is also high → POR, `o_cause`=1; held until lock returns, then 10+4 cycle release.
- `i_sil9024_reset` high for 1 cycle in RUN → `o_sil9024_reset` high for exactly 20 cycles. A second edge at cycle 15 extends the pulse to end at cycle 35.
- Re-trigger `i_reset_switch` in HOLD at count 7 → counter restarts; `o_reset` is high for 8+10 cycles total.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer_pkg
//  Description : Shared types, constants and helpers for the reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_POR   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STAGE = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR    = 2'd0,
        CAUSE_PLL    = 2'd1,
        CAUSE_BUTTON = 2'd2,
        CAUSE_SOFT   = 2'd3
    } cause_t;

    localparam int c_SYNC_STAGES = 2;

    // Microseconds to clock cycles, never less than one cycle.
    function automatic int us_to_cycles(input int freq, input int us);
        int cyc;
        cyc = (freq / 1_000_000) * us;
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : reset_debounce
//  Description : Synchronizer, debounce filter and rising-edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int CYCLES = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise
);

    localparam int                 c_CNT_W = $clog2(CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CYCLES - 1);

    logic [c_SYNC_STAGES-1:0] r_sync_q;
    logic [c_CNT_W-1:0]       r_cnt_q;
    logic [c_CNT_W-1:0]       w_cnt_d;
    logic                     r_level_q;
    logic                     w_level_d;
    logic                     r_rise_q;
    logic                     w_sample;

    assign w_sample = r_sync_q[c_SYNC_STAGES-1];

    // Counting only while the sample disagrees with the accepted level is
    // equivalent to restarting on every change of the synchronized input.
    always_comb begin
        w_cnt_d   = r_cnt_q;
        w_level_d = r_level_q;
        if (w_sample == r_level_q) begin
            w_cnt_d = '0;
        end else if (r_cnt_q >= c_LAST) begin
            w_level_d = w_sample;
            w_cnt_d   = '0;
        end else begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync_q  <= '0;
            r_cnt_q   <= '0;
            r_level_q <= 1'b0;
            r_rise_q  <= 1'b0;
        end else begin
            r_sync_q  <= {r_sync_q[c_SYNC_STAGES-2:0], i_async};
            r_cnt_q   <= w_cnt_d;
            r_level_q <= w_level_d;
            r_rise_q  <= w_level_d & ~r_level_q;
        end
    end

    assign o_rise = r_rise_q;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : System/CPU reset sequencing and SIL9024 reset stretching.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int FREQUENCY    = 100_000_000,
    parameter int HOLD_US      = 10,
    parameter int STAGE_CYCLES = 16,
    parameter int DEBOUNCE_US  = 1000,
    parameter int SIL_US       = 100
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_button,
    input  logic       i_pll_locked,
    input  logic       i_reset_switch,
    input  logic       i_sil9024_reset,
    output logic       o_reset,
    output logic       o_cpu_reset,
    output logic       o_sil9024_reset,
    output logic [1:0] o_cause,
    output logic       o_busy
);

    localparam int c_HOLD_CYC     = us_to_cycles(FREQUENCY, HOLD_US);
    localparam int c_DEBOUNCE_CYC = us_to_cycles(FREQUENCY, DEBOUNCE_US);
    localparam int c_SIL_CYC      = us_to_cycles(FREQUENCY, SIL_US);
    localparam int c_STAGE_CYC    = (STAGE_CYCLES < 1) ? 1 : STAGE_CYCLES;
    localparam int c_CNT_MAX      = (c_HOLD_CYC > c_STAGE_CYC) ? c_HOLD_CYC : c_STAGE_CYC;
    localparam int c_CNT_W        = $clog2(c_CNT_MAX + 1);
    localparam int c_SIL_W        = $clog2(c_SIL_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(c_HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STAGE_LAST = c_CNT_W'(c_STAGE_CYC - 1);
    localparam logic [c_SIL_W-1:0] c_SIL_LOAD   = c_SIL_W'(c_SIL_CYC);

    logic [c_SYNC_STAGES-1:0] r_pll_sync_q;
    logic                     w_pll_lost;
    logic                     w_btn_rise;
    logic                     w_restart;

    state_t                   r_state_q;
    state_t                   w_state_d;
    logic [c_CNT_W-1:0]       r_cnt_q;
    logic [c_CNT_W-1:0]       w_cnt_d;

    cause_t                   r_cause_q;
    cause_t                   w_cause_d;
    logic                     r_reset_q;
    logic                     w_reset_d;
    logic                     r_cpu_reset_q;
    logic                     w_cpu_reset_d;
    logic                     r_busy_q;
    logic                     w_busy_d;

    logic                     r_sil_prev_q;
    logic [c_SIL_W-1:0]       r_sil_cnt_q;
    logic [c_SIL_W-1:0]       w_sil_cnt_d;
    logic                     r_sil_q;
    logic                     w_sil_d;

    reset_debounce #(
        .CYCLES (c_DEBOUNCE_CYC)
    ) u_button (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_button),
        .o_rise  (w_btn_rise)
    );

    assign w_pll_lost = ~r_pll_sync_q[c_SYNC_STAGES-1];
    assign w_restart  = w_btn_rise | i_reset_switch;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state_q <= ST_POR;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = '0;
        case (r_state_q)
            ST_POR: begin
                if (!w_pll_lost) begin
                    w_state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_pll_lost) begin
                    w_state_d = ST_POR;
                end else if (w_restart) begin
                    w_state_d = ST_HOLD;
                end else if (r_cnt_q >= c_HOLD_LAST) begin
                    w_state_d = ST_STAGE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            ST_STAGE: begin
                if (w_pll_lost) begin
                    w_state_d = ST_POR;
                end else if (w_restart) begin
                    w_state_d = ST_HOLD;
                end else if (r_cnt_q >= c_STAGE_LAST) begin
                    w_state_d = ST_RUN;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (w_pll_lost) begin
                    w_state_d = ST_POR;
                end else if (w_restart) begin
                    w_state_d = ST_HOLD;
                end
            end
            default: begin
                w_state_d = ST_POR;
            end
        endcase
    end

    // Outputs decode the next state so they change in the same cycle as the
    // state register; POR waiting for lock is not a new cause.
    always_comb begin
        w_reset_d     = (w_state_d == ST_POR) || (w_state_d == ST_HOLD);
        w_cpu_reset_d = (w_state_d != ST_RUN);
        w_busy_d      = (w_state_d != ST_RUN);
        w_cause_d     = r_cause_q;
        if (r_state_q != ST_POR) begin
            if (w_pll_lost) begin
                w_cause_d = CAUSE_PLL;
            end else if (w_btn_rise) begin
                w_cause_d = CAUSE_BUTTON;
            end else if (i_reset_switch) begin
                w_cause_d = CAUSE_SOFT;
            end
        end
    end

    always_comb begin
        if (i_sil9024_reset && !r_sil_prev_q) begin
            w_sil_cnt_d = c_SIL_LOAD;
        end else if (r_sil_cnt_q != '0) begin
            w_sil_cnt_d = r_sil_cnt_q - 1'b1;
        end else begin
            w_sil_cnt_d = '0;
        end
        w_sil_d = i_sil9024_reset || (w_sil_cnt_d != '0) || w_reset_d;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pll_sync_q  <= '0;
            r_reset_q     <= 1'b1;
            r_cpu_reset_q <= 1'b1;
            r_busy_q      <= 1'b1;
            r_cause_q     <= CAUSE_POR;
            r_sil_prev_q  <= 1'b0;
            r_sil_cnt_q   <= '0;
            r_sil_q       <= 1'b1;
        end else begin
            r_pll_sync_q  <= {r_pll_sync_q[c_SYNC_STAGES-2:0], i_pll_locked};
            r_reset_q     <= w_reset_d;
            r_cpu_reset_q <= w_cpu_reset_d;
            r_busy_q      <= w_busy_d;
            r_cause_q     <= w_cause_d;
            r_sil_prev_q  <= i_sil9024_reset;
            r_sil_cnt_q   <= w_sil_cnt_d;
            r_sil_q       <= w_sil_d;
        end
    end

    assign o_reset         = r_reset_q;
    assign o_cpu_reset     = r_cpu_reset_q;
    assign o_busy          = r_busy_q;
    assign o_cause         = r_cause_q;
    assign o_sil9024_reset = r_sil_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Randomized and directed bench for reset_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int H  = 10;   // HOLD_CYC at 1 MHz, 10 us
    localparam int S  = 4;
    localparam int D  = 5;    // DEBOUNCE_CYC
    localparam int SC = 20;   // SIL_CYC

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       pll = 1'b1;
    logic       sw  = 1'b0;
    logic       sil = 1'b0;
    logic       o_reset;
    logic       o_cpu_reset;
    logic       o_sil;
    logic [1:0] o_cause;
    logic       o_busy;

    always #5 clk = ~clk;

    reset_sequencer #(
        .FREQUENCY    (1_000_000),
        .HOLD_US      (10),
        .STAGE_CYCLES (4),
        .DEBOUNCE_US  (5),
        .SIL_US       (20)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_button        (btn),
        .i_pll_locked    (pll),
        .i_reset_switch  (sw),
        .i_sil9024_reset (sil),
        .o_reset         (o_reset),
        .o_cpu_reset     (o_cpu_reset),
        .o_sil9024_reset (o_sil),
        .o_cause         (o_cause),
        .o_busy          (o_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: elapsed quiet time since the last restart decides the
    // phase; the button is accepted after D identical synchronized samples.
    bit m_armed = 1'b0;
    bit m_por = 1'b1;
    int m_quiet = 0;
    int m_cause = 0;
    int m_sil_rem = 0;
    bit m_sil_prev = 1'b0;
    bit m_p1 = 1'b0, m_p2 = 1'b0, m_b1 = 1'b0, m_b2 = 1'b0;
    bit m_acc = 1'b0, m_rise = 1'b0, m_stable = 1'b0, m_acc_new = 1'b0;
    bit m_bhist[$];

    always @(posedge clk) begin
        if (rst) begin
            m_armed = 1'b1; m_por = 1'b1; m_quiet = 0; m_cause = 0;
            m_sil_rem = 0; m_sil_prev = 1'b0;
            m_p1 = 1'b0; m_p2 = 1'b0; m_b1 = 1'b0; m_b2 = 1'b0;
            m_acc = 1'b0; m_rise = 1'b0;
            m_bhist.delete();
        end else begin
            if (m_por) begin
                if (m_p2) begin m_por = 1'b0; m_quiet = 0; end
            end else if (!m_p2) begin
                m_por = 1'b1; m_cause = 1;
            end else if (m_rise || sw) begin
                m_quiet = 0; m_cause = m_rise ? 2 : 3;
            end else if (m_quiet < H + S) begin
                m_quiet++;
            end
            if (sil && !m_sil_prev) m_sil_rem = SC;
            else if (m_sil_rem > 0) m_sil_rem--;
            m_sil_prev = sil;
            m_bhist.push_back(m_b2);
            if (m_bhist.size() > D) void'(m_bhist.pop_front());
            m_stable = (m_bhist.size() == D);
            foreach (m_bhist[i]) if (m_bhist[i] != m_b2) m_stable = 1'b0;
            m_acc_new = m_stable ? m_b2 : m_acc;
            m_rise = m_acc_new && !m_acc;
            m_acc = m_acc_new;
            m_p2 = m_p1; m_p1 = pll;
            m_b2 = m_b1; m_b1 = btn;
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            check_eq("o_reset",     32'(o_reset),     32'(m_por || m_quiet < H));
            check_eq("o_cpu_reset", 32'(o_cpu_reset), 32'(m_por || m_quiet < H + S));
            check_eq("o_busy",      32'(o_busy),      32'(m_por || m_quiet < H + S));
            check_eq("o_cause",     32'(o_cause),     32'(m_cause));
            check_eq("o_sil",       32'(o_sil),
                     32'(m_sil_prev || m_sil_rem != 0 || m_por || m_quiet < H));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int cnt;

    initial begin
        rst = 1'b1; pll = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        check_eq("boot_cause", 32'(o_cause), 32'd0);
        check_eq("boot_busy",  32'(o_busy),  32'd0);

        sw = 1'b1; tick(1); sw = 1'b0;
        tick(20);
        check_eq("sw_cause", 32'(o_cause), 32'd3);

        repeat (2) begin
            btn = 1'b1; tick(3); btn = 1'b0; tick(8);
        end
        check_eq("glitch_cause", 32'(o_cause), 32'd3);
        btn = 1'b1; tick(6); btn = 1'b0;
        tick(25);
        check_eq("button_cause", 32'(o_cause), 32'd2);

        // PLL loss lands in STAGE together with a software request.
        sw = 1'b1; tick(1); sw = 1'b0;
        tick(8);
        pll = 1'b0; tick(2);
        sw = 1'b1; tick(1); sw = 1'b0;
        tick(10);
        check_eq("pll_hold_reset", 32'(o_reset), 32'd1);
        pll = 1'b1;
        tick(25);
        check_eq("pll_cause", 32'(o_cause), 32'd1);

        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            sil = (i == 0); tick(1);
            if (o_sil) cnt++;
        end
        check_eq("sil_width", 32'(cnt), 32'd20);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            sil = (i == 0 || i == 15); tick(1);
            if (o_sil) cnt++;
        end
        check_eq("sil_extend", 32'(cnt), 32'd35);

        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            sw = (i == 0 || i == 8); tick(1);
            if (o_reset) cnt++;
        end
        check_eq("retrigger_width", 32'(cnt), 32'd18);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 999) < 3);
            if (pll) pll = ($urandom_range(0, 99) >= 1);
            else     pll = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 8) btn = ~btn;
            sw  = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 4) sil = ~sil;
            tick(1);
        end
        rst = 1'b0; pll = 1'b1; btn = 1'b0; sw = 1'b0; sil = 1'b0;
        tick(40);
        check_eq("final_busy", 32'(o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
